// File: rtl/tl_egress_credit_pkg.sv
// Shared definitions for the transaction-layer egress drain stage:
// default widths, credit constants and the FSM state encoding.
package tl_egress_credit_pkg;

    localparam int DEF_DATA_W       = 4;
    localparam int DEF_CREDIT_W     = 4;
    localparam int DEF_INIT_CREDITS = 8;
    localparam int DEF_MAX_CREDITS  = 15;
    localparam int DEF_CNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } egress_state_t;

endpackage

// File: rtl/tl_egress_credit_if.sv
// Bundle of the main-FIFO read side and the link-partner valid/ready side.
// master = the egress stage, slave = FIFO plus link partner.
interface tl_egress_credit_if
    import tl_egress_credit_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              EMPTYffg;
    logic [DATA_W-1:0] DATO_INffg;
    logic              POPffg;
    logic [DATA_W-1:0] DATO_OUT;
    logic              VALID_OUT;
    logic              READY_IN;
    logic              CREDIT_RET;

    modport master (
        input  EMPTYffg,
        input  DATO_INffg,
        input  READY_IN,
        input  CREDIT_RET,
        output POPffg,
        output DATO_OUT,
        output VALID_OUT
    );

    modport slave (
        output EMPTYffg,
        output DATO_INffg,
        output READY_IN,
        output CREDIT_RET,
        input  POPffg,
        input  DATO_OUT,
        input  VALID_OUT
    );

endinterface

// File: rtl/tl_egress_credit_counter.sv
// Link credit counter: +1 per returned credit, -1 per pop, saturating at the
// ceiling with a sticky flag raised when a credit comes back while full.
module tl_egress_credit_counter
    import tl_egress_credit_pkg::*;
#(
    parameter int CREDIT_W     = DEF_CREDIT_W,
    parameter int INIT_CREDITS = DEF_INIT_CREDITS,
    parameter int MAX_CREDITS  = DEF_MAX_CREDITS
)(
    input  logic                clk,
    input  logic                rst_b,
    input  logic                inc,
    input  logic                dec,
    output logic [CREDIT_W-1:0] count,
    output logic                overflow
);

    localparam logic [CREDIT_W-1:0] INIT_V = CREDIT_W'(INIT_CREDITS);
    localparam logic [CREDIT_W-1:0] MAX_V  = CREDIT_W'(MAX_CREDITS);

    // Return and pop in the same cycle cancel; never wrap in either direction.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            count    <= INIT_V;
            overflow <= 1'b0;
        end else begin
            if (inc && (count == MAX_V)) begin
                overflow <= 1'b1;
            end
            if (inc && !dec && (count != MAX_V)) begin
                count <= count + 1'b1;
            end else if (dec && !inc && (count != '0)) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_egress_credit.sv
// Egress drain stage: pops the main FIFO one word at a time when credits are
// available and presents each word on a valid/ready link toward the partner.
module tl_egress_credit
    import tl_egress_credit_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CREDIT_W     = DEF_CREDIT_W,
    parameter int INIT_CREDITS = DEF_INIT_CREDITS,
    parameter int MAX_CREDITS  = DEF_MAX_CREDITS,
    parameter int CNT_W        = DEF_CNT_W
)(
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    tl_egress_credit_if.master    bus,
    output logic [CREDIT_W-1:0]   CREDITS,
    output logic                  STALL,
    output logic                  CREDIT_ERR,
    output logic [CNT_W-1:0]      WORD_CNT
);

    egress_state_t     state;
    egress_state_t     state_next;
    logic [DATA_W-1:0] data_q;
    logic              can_pop;
    logic              handshake;

    assign can_pop   = ENABLE & ~bus.EMPTYffg & (CREDITS != '0);
    assign handshake = (state == ST_SEND) & bus.READY_IN;

    // Pop strobe and valid are decoded from the state register, so both are
    // glitch-free and a pop can never repeat on consecutive cycles.
    assign bus.POPffg    = (state == ST_POP);
    assign bus.VALID_OUT = (state == ST_SEND);
    assign bus.DATO_OUT  = data_q;
    assign STALL         = ~bus.EMPTYffg & ENABLE & (CREDITS == '0) & (state == ST_IDLE);

    tl_egress_credit_counter #(
        .CREDIT_W     (CREDIT_W),
        .INIT_CREDITS (INIT_CREDITS),
        .MAX_CREDITS  (MAX_CREDITS)
    ) u_credit (
        .clk      (CLOCK),
        .rst_b    (RESET),
        .inc      (bus.CREDIT_RET),
        .dec      (bus.POPffg),
        .count    (CREDITS),
        .overflow (CREDIT_ERR)
    );

    // State register.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one pop, one wait for FIFO read data, then hold until accepted.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (can_pop) state_next = ST_POP;
            ST_POP:  state_next = ST_WAIT;
            ST_WAIT: state_next = ST_SEND;
            ST_SEND: if (bus.READY_IN) state_next = can_pop ? ST_POP : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture FIFO read data the cycle after the pop; held through and after the handshake.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            data_q <= '0;
        end else if (state == ST_WAIT) begin
            data_q <= bus.DATO_INffg;
        end
    end

    // Count completed link handshakes; wraps naturally.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            WORD_CNT <= '0;
        end else if (handshake) begin
            WORD_CNT <= WORD_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_tl_egress_credit.sv
module tb_tl_egress_credit;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] credits;
    logic       stall;
    logic       credit_err;
    logic [7:0] word_cnt;

    tl_egress_credit_if #(.DATA_W(4)) bus ();

    tl_egress_credit dut (
        .CLOCK      (clk),
        .RESET      (rst_n),
        .ENABLE     (enable),
        .bus        (bus),
        .CREDITS    (credits),
        .STALL      (stall),
        .CREDIT_ERR (credit_err),
        .WORD_CNT   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard / FIFO model
    logic [3:0] fifo_q [$];
    logic [3:0] exp_q  [$];
    time        pop_times [$];
    time        hs_times  [$];

    int dir_checks = 0;
    int dir_fail   = 0;
    int mon_checks = 0;
    int mon_fail   = 0;
    int hs_count   = 0;
    int pop_cnt    = 0;
    logic prev_pop = 1'b0;

    // monitor: samples mid-cycle, before the edge that completes the transfer
    always @(negedge clk) begin
        if (bus.POPffg === 1'b1) begin
            mon_checks++;
            if (prev_pop || credits == 4'd0) begin
                mon_fail++;
                $display("FAIL pop_legal: prev_pop=%0b credits=%0d required prev_pop=0 credits>0", prev_pop, credits);
            end
            pop_cnt++;
            pop_times.push_back($time);
        end
        prev_pop = (bus.POPffg === 1'b1);
        if (bus.VALID_OUT === 1'b1 && bus.READY_IN === 1'b1) begin
            mon_checks++;
            if (exp_q.size() == 0) begin
                mon_fail++;
                $display("FAIL word_out: got %h with no word expected", bus.DATO_OUT);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (bus.DATO_OUT !== e) begin
                    mon_fail++;
                    $display("FAIL word_out: got %h expected %h", bus.DATO_OUT, e);
                end
            end
            hs_count++;
            hs_times.push_back($time);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        dir_checks++;
        if (act !== exp) begin
            dir_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // advance one cycle; FIFO model pops after the edge that ends the POP cycle
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.POPffg === 1'b1) begin
            chk("pop_nonempty", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) bus.DATO_INffg = fifo_q.pop_front();
        end
        bus.EMPTYffg = (fifo_q.size() == 0);
    endtask

    task automatic load(input logic [3:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        bus.EMPTYffg = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (hs_count >= target) break;
            tick();
        end
        chk("handshake_count", hs_count, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time        t_rel;
        logic [3:0] words7 [7];
        logic       ret_done;
        logic       ret_pending;
        int         target;
        int         pc;
        logic [7:0] wc;

        words7 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h0, 4'h7};
        rst_n          = 1'b0;
        enable         = 1'b1;
        bus.EMPTYffg   = 1'b1;
        bus.DATO_INffg = 4'h0;
        bus.READY_IN   = 1'b1;
        bus.CREDIT_RET = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_valid", bus.VALID_OUT, 0);
        chk("rst_pop", bus.POPffg, 0);
        chk("rst_data", bus.DATO_OUT, 0);
        chk("rst_credits", credits, 8);
        chk("rst_stall", stall, 0);
        chk("rst_cerr", credit_err, 0);
        chk("rst_wcnt", word_cnt, 0);

        // three words back to back, READY_IN tied high
        load(4'hA);
        load(4'h5);
        load(4'h3);
        rst_n = 1'b1;
        t_rel = $time;
        wait_hs(3, 40);
        chk("t1_pop0_time", 32'(pop_times[0] - t_rel), 14);
        chk("t1_pop_spacing1", 32'(pop_times[1] - pop_times[0]), 30);
        chk("t1_pop_spacing2", 32'(pop_times[2] - pop_times[1]), 30);
        chk("t1_valid_time", 32'(hs_times[0] - t_rel), 34);
        chk("t1_credits", credits, 5);
        chk("t1_wcnt", word_cnt, 3);
        chk("t1_valid_idle", bus.VALID_OUT, 0);
        chk("t1_data_hold", bus.DATO_OUT, 4'h3);

        // drain all credits; one pop coincides with a credit return at CREDITS==3
        for (int i = 0; i < 7; i++) load(words7[i]);
        ret_done    = 1'b0;
        ret_pending = 1'b0;
        target      = hs_count + 6;
        for (int i = 0; i < 120; i++) begin
            if (hs_count >= target) break;
            tick();
            if (ret_pending) begin
                bus.CREDIT_RET = 1'b0;
                ret_pending    = 1'b0;
                chk("pop_and_return_same_cycle", credits, 3);
            end else if (!ret_done && bus.POPffg === 1'b1 && credits == 4'd3) begin
                bus.CREDIT_RET = 1'b1;
                ret_done       = 1'b1;
                ret_pending    = 1'b1;
            end
        end
        chk("t2_return_injected", ret_done, 1);
        chk("t2_six_sent", hs_count, target);
        tick();
        tick();
        tick();
        chk("t2_stall", stall, 1);
        chk("t2_credits_zero", credits, 0);
        chk("t2_valid_low", bus.VALID_OUT, 0);
        chk("t2_wcnt", word_cnt, 9);
        bus.CREDIT_RET = 1'b1;
        tick();
        bus.CREDIT_RET = 1'b0;
        wait_hs(target + 1, 20);
        chk("t2_credits_after", credits, 0);
        chk("t2_wcnt_after", word_cnt, 10);

        // partner backpressure for 5 cycles, then ENABLE dropped mid-word
        bus.CREDIT_RET = 1'b1;
        tick();
        tick();
        bus.CREDIT_RET = 1'b0;
        chk("t3_credits", credits, 2);
        bus.READY_IN = 1'b0;
        load(4'h9);
        load(4'h6);
        for (int i = 0; i < 20; i++) begin
            if (bus.VALID_OUT === 1'b1) break;
            tick();
        end
        chk("t3_valid_reached", bus.VALID_OUT, 1);
        pc = pop_cnt;
        wc = word_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", bus.VALID_OUT, 1);
            chk("t3_hold_data", bus.DATO_OUT, 4'h9);
        end
        chk("t3_no_extra_pop", pop_cnt, pc);
        chk("t3_wcnt_hold", word_cnt, wc);
        chk("t3_credits_hold", credits, 1);
        enable       = 1'b0;
        bus.READY_IN = 1'b1;
        wait_hs(hs_count + 1, 10);
        tick();
        tick();
        tick();
        tick();
        chk("t3_disabled_no_pop", pop_cnt, pc);
        chk("t3_disabled_valid", bus.VALID_OUT, 0);
        chk("t3_disabled_stall", stall, 0);
        enable = 1'b1;
        wait_hs(hs_count + 1, 20);
        chk("t3_wcnt", word_cnt, 12);
        chk("t3_credits_end", credits, 0);

        // saturate at 15 and raise the sticky overflow flag
        bus.CREDIT_RET = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("t4_credits_max", credits, 15);
        chk("t4_cerr_before", credit_err, 0);
        tick();
        bus.CREDIT_RET = 1'b0;
        chk("t4_credits_sat", credits, 15);
        chk("t4_cerr_set", credit_err, 1);
        tick();
        tick();
        tick();
        chk("t4_cerr_sticky", credit_err, 1);

        // reset while the word is in WAIT discards it
        load(4'hC);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.POPffg === 1'b1) break;
        end
        chk("t6_pop_seen", bus.POPffg, 1);
        tick();
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        pc = pop_cnt;
        tick();
        chk("t6_valid", bus.VALID_OUT, 0);
        chk("t6_credits", credits, 8);
        chk("t6_wcnt", word_cnt, 0);
        chk("t6_cerr", credit_err, 0);
        chk("t6_data", bus.DATO_OUT, 0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("t6_no_word", bus.VALID_OUT, 0);
        chk("t6_no_pop", pop_cnt, pc);
        chk("t6_scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", dir_checks + mon_checks, dir_fail + mon_fail);
        $finish;
    end

endmodule
